core_interconnect: RTL and testbench

// - Point-to-point spike/message interconnect between two neuromorphic cores (port A, port B).
// - Each write carries a destination neuron address plus a 32-bit payload.
// - The address selects the owning core; the entry is queued in that core's receive FIFO.
// - A core drains its own FIFO through its read port.

---
 rtl/core_interconnect_if.sv | 41 ++++
 rtl/core_interconnect.sv | 107 ++++++++++
 tb/tb_core_interconnect.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/core_interconnect_if.sv
// Bus bundle between the two neuromorphic cores and core_interconnect.
// a_out_valid/b_out_valid exist only when INTERCONNECT_OUT_VALID_EN is defined.
interface core_interconnect_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] a_n_addr_in;
    logic [DATA_WIDTH-1:0] a_data_in;
    logic [ADDR_WIDTH-1:0] a_n_addr_out;
    logic [DATA_WIDTH-1:0] a_data_out;
    logic                  a_read_en;
    logic                  a_write_en;
    logic [ADDR_WIDTH-1:0] b_n_addr_in;
    logic [DATA_WIDTH-1:0] b_data_in;
    logic [ADDR_WIDTH-1:0] b_n_addr_out;
    logic [DATA_WIDTH-1:0] b_data_out;
    logic                  b_read_en;
    logic                  b_write_en;
`ifdef INTERCONNECT_OUT_VALID_EN
    logic                  a_out_valid;
    logic                  b_out_valid;
`endif

    modport master (
        output a_n_addr_in, a_data_in, a_read_en, a_write_en,
        output b_n_addr_in, b_data_in, b_read_en, b_write_en,
        input  a_n_addr_out, a_data_out, b_n_addr_out, b_data_out
`ifdef INTERCONNECT_OUT_VALID_EN
        , input a_out_valid, b_out_valid
`endif
    );

    modport slave (
        input  a_n_addr_in, a_data_in, a_read_en, a_write_en,
        input  b_n_addr_in, b_data_in, b_read_en, b_write_en,
        output a_n_addr_out, a_data_out, b_n_addr_out, b_data_out
`ifdef INTERCONNECT_OUT_VALID_EN
        , output a_out_valid, b_out_valid
`endif
    );
endinterface

// File: rtl/core_interconnect.sv
// Two-core spike interconnect: address-routed writes into per-core receive FIFOs.
// Optional macro INTERCONNECT_OUT_VALID_EN adds one-cycle pop-valid outputs.
module core_interconnect #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int A_LO       = 0,
    parameter int A_HI       = 0,
    parameter int B_LO       = 1,
    parameter int B_HI       = 2
) (
    input  logic               clk,
    input  logic               reset,
    core_interconnect_if.slave bus
);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [EW-1:0] entry_t;

    function automatic logic in_rng(input int addr, input int lo, input int hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

    entry_t          w_ent_a, w_ent_b;
    logic            w_ren     [2];
    logic            w_route_a [2];
    logic            w_route_b [2];
    logic            w_pop     [2];
    logic            w_acc_a   [2];
    logic            w_acc_b   [2];
    logic [CW-1:0]   w_free    [2];
    logic [CW-1:0]   w_need_b  [2];

    entry_t          r_mem  [2][FIFO_DEPTH];
    logic [PW-1:0]   r_wptr [2];
    logic [PW-1:0]   r_rptr [2];
    logic [CW-1:0]   r_cnt  [2];
    entry_t          r_out  [2];
`ifdef INTERCONNECT_OUT_VALID_EN
    logic            r_vld  [2];
`endif

    // Index 0 is FIFO_A, index 1 is FIFO_B; port A's push always wins a single free slot.
    always_comb begin
        w_ent_a      = {bus.a_n_addr_in, bus.a_data_in};
        w_ent_b      = {bus.b_n_addr_in, bus.b_data_in};
        w_ren[0]     = bus.a_read_en;
        w_ren[1]     = bus.b_read_en;
        w_route_a[0] = bus.a_write_en && in_rng(int'(bus.a_n_addr_in), A_LO, A_HI);
        w_route_a[1] = bus.a_write_en && in_rng(int'(bus.a_n_addr_in), B_LO, B_HI);
        w_route_b[0] = bus.b_write_en && in_rng(int'(bus.b_n_addr_in), A_LO, A_HI);
        w_route_b[1] = bus.b_write_en && in_rng(int'(bus.b_n_addr_in), B_LO, B_HI);
        for (int unsigned f = 0; f < 2; f++) begin
            w_pop[f]    = w_ren[f] && (r_cnt[f] != '0);
            w_free[f]   = CW'(FIFO_DEPTH) - r_cnt[f];
            w_acc_a[f]  = w_route_a[f] && (w_free[f] != '0);
            w_need_b[f] = w_acc_a[f] ? CW'(2) : CW'(1);
            w_acc_b[f]  = w_route_b[f] && (w_free[f] >= w_need_b[f]);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned f = 0; f < 2; f++) begin
            if (w_acc_a[f])
                r_mem[f][r_wptr[f]] <= w_ent_a;
            if (w_acc_b[f])
                r_mem[f][r_wptr[f] + PW'(w_acc_a[f])] <= w_ent_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned f = 0; f < 2; f++) begin
                r_wptr[f] <= '0;
                r_rptr[f] <= '0;
                r_cnt[f]  <= '0;
                r_out[f]  <= '0;
`ifdef INTERCONNECT_OUT_VALID_EN
                r_vld[f]  <= 1'b0;
`endif
            end
        end else begin
            for (int unsigned f = 0; f < 2; f++) begin
                r_wptr[f] <= r_wptr[f] + PW'(w_acc_a[f]) + PW'(w_acc_b[f]);
                r_cnt[f]  <= r_cnt[f] - CW'(w_pop[f]) + CW'(w_acc_a[f]) + CW'(w_acc_b[f]);
                if (w_pop[f]) begin
                    r_rptr[f] <= r_rptr[f] + PW'(1);
                    r_out[f]  <= r_mem[f][r_rptr[f]];
                end
`ifdef INTERCONNECT_OUT_VALID_EN
                r_vld[f]  <= w_pop[f];
`endif
            end
        end
    end

    assign bus.a_n_addr_out = r_out[0][EW-1:DATA_WIDTH];
    assign bus.a_data_out   = r_out[0][DATA_WIDTH-1:0];
    assign bus.b_n_addr_out = r_out[1][EW-1:DATA_WIDTH];
    assign bus.b_data_out   = r_out[1][DATA_WIDTH-1:0];
`ifdef INTERCONNECT_OUT_VALID_EN
    assign bus.a_out_valid  = r_vld[0];
    assign bus.b_out_valid  = r_vld[1];
`endif
endmodule

// File: tb/tb_core_interconnect.sv
// Directed bench for core_interconnect: routing, empty/full FIFOs, contention, unmapped and async reset.
// Valid-output checks are included when INTERCONNECT_OUT_VALID_EN is defined.
module tb_core_interconnect;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    core_interconnect_if #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) bif ();

    core_interconnect #(
        .ADDR_WIDTH(2), .DATA_WIDTH(32), .FIFO_DEPTH(4),
        .A_LO(0), .A_HI(0), .B_LO(1), .B_HI(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.a_write_en = 1'b0; bif.a_read_en = 1'b0;
        bif.b_write_en = 1'b0; bif.b_read_en = 1'b0;
    endtask

    task automatic wr_a(input logic [1:0] ad, input logic [31:0] d);
        bif.a_write_en = 1'b1; bif.a_n_addr_in = ad; bif.a_data_in = d;
    endtask

    task automatic wr_b(input logic [1:0] ad, input logic [31:0] d);
        bif.b_write_en = 1'b1; bif.b_n_addr_in = ad; bif.b_data_in = d;
    endtask

    task automatic chk_a(input string tag, input logic [1:0] ad, input logic [31:0] d);
        check(tag, 64'({bif.a_n_addr_out, bif.a_data_out}), 64'({ad, d}));
    endtask

    task automatic chk_b(input string tag, input logic [1:0] ad, input logic [31:0] d);
        check(tag, 64'({bif.b_n_addr_out, bif.b_data_out}), 64'({ad, d}));
    endtask

    task automatic chk_v(input string tag, input logic va, input logic vb);
`ifdef INTERCONNECT_OUT_VALID_EN
        check({tag, "_va"}, 64'(bif.a_out_valid), 64'(va));
        check({tag, "_vb"}, 64'(bif.b_out_valid), 64'(vb));
`else
        if (tag.len() < 0) $display("%b%b", va, vb);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        bif.a_n_addr_in = '0; bif.a_data_in = '0;
        bif.b_n_addr_in = '0; bif.b_data_in = '0;
        idle();

        // Reset state, then reads on empty FIFOs
        #10;
        chk_a("rst_a", 2'b00, 32'h0);
        chk_b("rst_b", 2'b00, 32'h0);
        chk_v("rst", 1'b0, 1'b0);
        reset = 1'b1;
        bif.a_read_en = 1'b1; bif.b_read_en = 1'b1;
        step();
        chk_a("rst_rd_a", 2'b00, 32'h0);
        chk_b("rst_rd_b", 2'b00, 32'h0);
        chk_v("rst_rd", 1'b0, 1'b0);

        // Push into empty FIFO_A while reading: no bypass, popped next cycle
        idle();
        bif.a_read_en = 1'b1;
        wr_b(2'b00, 32'h55555555);
        step();
        chk_a("nobypass_a", 2'b00, 32'h0);
        idle();
        bif.a_read_en = 1'b1;
        step();
        chk_a("bypass_pop_a", 2'b00, 32'h55555555);
        chk_v("bypass_pop", 1'b1, 1'b0);

        // Routing
        idle();
        wr_a(2'b01, 32'hA5A5A5A5); wr_b(2'b00, 32'hABABABAB);
        step();
        wr_a(2'b10, 32'hAAAAAAAA); wr_b(2'b00, 32'hBBBBBBAB);
        step();
        idle();
        bif.a_read_en = 1'b1; bif.b_read_en = 1'b1;
        step();
        chk_a("route1_a", 2'b00, 32'hABABABAB);
        chk_b("route1_b", 2'b01, 32'hA5A5A5A5);
        chk_v("route1", 1'b1, 1'b1);
        step();
        chk_a("route2_a", 2'b00, 32'hBBBBBBAB);
        chk_b("route2_b", 2'b10, 32'hAAAAAAAA);
        step();
        chk_a("empty_a", 2'b00, 32'hBBBBBBAB);
        chk_b("empty_b", 2'b10, 32'hAAAAAAAA);
        chk_v("empty", 1'b0, 1'b0);

        // Full FIFO_B: fifth push is lost
        idle();
        for (int i = 0; i < 5; i++) begin
            wr_a(2'b01, 32'h10000001 + 32'(i));
            step();
        end
        idle();
        bif.b_read_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_b($sformatf("full_rd%0d", i), 2'b01, 32'h10000001 + 32'((i < 4) ? i : 3));
        end

        // One free slot with both ports pushing: A stored, B dropped
        idle();
        for (int i = 0; i < 3; i++) begin
            wr_a(2'b01, 32'h30000001 + 32'(i));
            step();
        end
        wr_a(2'b01, 32'h3000000A); wr_b(2'b10, 32'h3000000B);
        step();
        idle();
        bif.b_read_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_b($sformatf("slot_rd%0d", i), 2'b01, 32'h30000001 + 32'(i));
        end
        step();
        chk_b("slot_rd3", 2'b01, 32'h3000000A);
        step();
        chk_b("slot_rd4", 2'b01, 32'h3000000A);

        // Contention on FIFO_B: A before B
        idle();
        wr_a(2'b01, 32'h11111111); wr_b(2'b10, 32'h22222222);
        step();
        idle();
        bif.b_read_en = 1'b1;
        step();
        chk_b("cont1_b", 2'b01, 32'h11111111);
        step();
        chk_b("cont2_b", 2'b10, 32'h22222222);

        // Unmapped address is dropped
        idle();
        wr_a(2'b11, 32'hDEADBEEF); wr_b(2'b11, 32'hDEADBEEF);
        step();
        idle();
        bif.a_read_en = 1'b1; bif.b_read_en = 1'b1;
        step();
        chk_a("unmap_a", 2'b00, 32'hBBBBBBAB);
        chk_b("unmap_b", 2'b10, 32'h22222222);
        chk_v("unmap", 1'b0, 1'b0);

        // Async reset with entries queued
        idle();
        wr_a(2'b00, 32'hCAFE0000); wr_b(2'b01, 32'hCAFE0001);
        step();
        idle();
        #2 reset = 1'b0;
        #1;
        chk_a("arst_a", 2'b00, 32'h0);
        chk_b("arst_b", 2'b00, 32'h0);
        step();
        reset = 1'b1;
        bif.a_read_en = 1'b1; bif.b_read_en = 1'b1;
        step();
        chk_a("arst_rd_a", 2'b00, 32'h0);
        chk_b("arst_rd_b", 2'b00, 32'h0);
        chk_v("arst_rd", 1'b0, 1'b0);

        idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
